// File: rtl/lsu_pkg.sv
// Shared LSU encodings: access-size codes and controller FSM states.
// Latency: none (types only).
// Backpressure: n/a.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WAIT   = 2'b10,
        RESP   = 2'b11
    } state_e;

endpackage

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of raw memory read data to the access size.
// Latency: combinational.
// Backpressure: n/a.
module lsu_load_ext
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] raw_dat,
    input  size_e            size,
    input  logic             is_unsigned,
    output logic [WIDTH-1:0] ext_dat
);

    always_comb begin
        ext_dat = '0;
        case (size)
            SZ_BYTE: ext_dat = {{(WIDTH-8){raw_dat[7] & ~is_unsigned}}, raw_dat[7:0]};
            SZ_HALF: ext_dat = {{(WIDTH-16){raw_dat[15] & ~is_unsigned}}, raw_dat[15:0]};
            SZ_WORD: ext_dat = raw_dat;
            default: ext_dat = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one request at a time to a simple data memory (LSU_MISALIGN_TRAP_EN traps misaligned half/word).
// Latency: accept at edge N, response first sampled by the consumer at edge N+2+MEM_LAT.
// Backpressure: req_ready only in IDLE; response held in RESP until rsp_ready.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 20,
    parameter int MEM_LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [DEPTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic [DEPTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_data_in,
    output logic             mem_wr,
    output logic             mem_rd,
    output logic             mem_one_byte,
    output logic             mem_two_bytes,
    output logic             mem_four_bytes,
    input  logic [WIDTH-1:0] mem_data_out
);

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    state_e           state_q, state_d;
    logic             we_q, we_d;
    size_e            size_q, size_d;
    logic             uns_q, uns_d;
    logic [DEPTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             illegal;
    logic             active;
    logic [WIDTH-1:0] ext_dat;

    lsu_load_ext #(.WIDTH(WIDTH)) u_load_ext (
        .raw_dat     (mem_data_out),
        .size        (size_q),
        .is_unsigned (uns_q),
        .ext_dat     (ext_dat)
    );

    always_comb begin
        illegal = (req_size == SZ_RSVD);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_size == SZ_HALF) && req_addr[0])
            illegal = 1'b1;
        if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
            illegal = 1'b1;
`endif
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = size_e'(req_size);
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = illegal;
                    state_d = illegal ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (LAT == 3'd0) begin
                    state_d = RESP;
                    rdata_d = we_q ? '0 : ext_dat;
                end else begin
                    state_d = WAIT;
                    cnt_d   = LAT - 3'd1;
                end
            end
            WAIT: begin
                // Memory output is sampled only on the edge leaving the final wait cycle.
                if (cnt_q == 3'd0) begin
                    state_d = RESP;
                    rdata_d = we_q ? '0 : ext_dat;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= 3'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Memory strobes decode from the state flop only, so they are glitch-free for a whole period.
    assign active         = (state_q == ACCESS) || (state_q == WAIT);
    assign mem_wr         = active & we_q;
    assign mem_rd         = active & ~we_q;
    assign mem_one_byte   = active && (size_q == SZ_BYTE);
    assign mem_two_bytes  = active && (size_q == SZ_HALF);
    assign mem_four_bytes = active && (size_q == SZ_WORD);
    assign mem_addr       = active ? addr_q  : '0;
    assign mem_data_in    = active ? wdata_q : '0;

    assign req_ready = (state_q == IDLE) && !rst;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width in bits.
REQ-002 SHALL have parameter DEPTH, default 20: byte-address width in bits.
REQ-003 SHALL have parameter MEM_LAT, default 0: extra wait cycles before read data is sampled, range 0..7.
REQ-004 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-006 SHALL have ports req_valid / req_ready  in/out  1 each: request handshake.
REQ-007 SHALL have port req_we  input  1: 1 = store, 0 = load.
REQ-008 SHALL have port req_size  input  2: 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port req_unsigned  input  1: zero-extend loads (lbu/lhu).
REQ-010 SHALL have ports req_addr  input  DEPTH and req_wdata  input  WIDTH.
REQ-011 SHALL have ports rsp_valid / rsp_ready  out/in  1 each: response handshake.
REQ-012 SHALL have ports rsp_rdata  output  WIDTH and rsp_err  output  1.
REQ-013 SHALL have memory-side outputs: mem_addr (DEPTH), mem_data_in (WIDTH), mem_wr, mem_rd, mem_one_byte, mem_two_bytes, mem_four_bytes (1 each).
REQ-014 SHALL have memory-side input mem_data_out  WIDTH: zero-extended read data from data memory.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, WAIT, RESP.
REQ-016 In IDLE, req_ready SHALL be 1; on req_valid it SHALL latch the request and go to ACCESS, or to RESP with rsp_err=1 if the request is illegal.
REQ-017 Outside IDLE, req_ready SHALL be 0.
REQ-018 In ACCESS and WAIT, the mem_* outputs SHALL be driven from latched request state: mem_wr=we, mem_rd=!we, and exactly one size strobe high.
REQ-019 In all other states, mem_wr, mem_rd and every size strobe SHALL be 0.
REQ-020 The mem_* outputs SHALL be decoded combinationally from state, so they hold stable for a full clock period (a negedge write lands once).
REQ-021 ACCESS SHALL last 1 cycle and WAIT SHALL last MEM_LAT cycles; WAIT SHALL be skipped when MEM_LAT=0.
REQ-022 Load data SHALL be sampled into rsp_rdata at the rising edge leaving the last ACCESS/WAIT cycle.
REQ-023 Latency SHALL be: request accepted at edge N, rsp_valid high from edge N+2+MEM_LAT.
REQ-024 Loads SHALL be extended: byte sign bit 7, half sign bit 15, unless req_unsigned=1; word loads pass through unchanged.
REQ-025 Stores SHALL return rsp_rdata=0 and rsp_err=0.
REQ-026 req_size=11 SHALL be illegal: no memory strobe, rsp_err=1, rsp_rdata=0.
REQ-027 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL be held stable until rsp_ready=1, then the FSM SHALL return to IDLE.
REQ-028 No new request SHALL be accepted in the cycle rsp_ready is sampled; back-to-back throughput SHALL be one transaction per 3+MEM_LAT cycles.
REQ-029 An address at 2**DEPTH-1 with multi-byte size SHALL be passed unmodified; wrap-around is the memory's responsibility.

Reset
REQ-030 While rst=1, the FSM SHALL be IDLE asynchronously.
REQ-031 While rst=1, outputs SHALL be: req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, and all mem_* outputs=0.
REQ-032 After rst deasserts, req_ready SHALL read 1 from the first cycle.
REQ-033 Reset mid-ACCESS SHALL drop the strobes immediately and discard the transaction, with no response.

Configuration
REQ-034 Macro LSU_MISALIGN_TRAP_EN SHALL control misalignment handling.
REQ-035 With LSU_MISALIGN_TRAP_EN defined: half with addr[0]!=0, or word with addr[1:0]!=0, SHALL be illegal and handled per REQ-026.
REQ-036 Without LSU_MISALIGN_TRAP_EN: misaligned accesses SHALL be issued as-is, and rsp_err SHALL assert only for size 11.

Structure
REQ-037 Package lsu_pkg SHALL hold the size encoding enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD) and the FSM state enum.
REQ-038 Sub-module lsu_load_ext (combinational: raw data, size, unsigned -> extended data) SHALL be instantiated once.

Verification
REQ-039 Store word 0xDEADBEEF @0x10, then load word @0x10 SHALL give rsp_rdata=0xDEADBEEF, err=0, rsp_valid at N+2+MEM_LAT.
REQ-040 Memory byte 0x80 @0x20: lb SHALL give 0xFFFFFF80 and lbu SHALL give 0x00000080; lh over 0x8001 SHALL give 0xFFFF8001.
REQ-041 req_size=11 SHALL give rsp_err=1 and no mem_wr/mem_rd pulse.
REQ-042 Word load @0x13 SHALL give err=1 with no strobe when LSU_MISALIGN_TRAP_EN is defined, and a normal access without it.
REQ-043 rsp_ready held 0 for 5 cycles SHALL keep the response stable with req_ready=0; a new req_valid SHALL be ignored until IDLE.
REQ-044 rst pulsed during ACCESS of a store SHALL drop strobes the same cycle, produce no rsp_valid, and give req_ready=1 after release.
